// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO buffer.
// Defaults here set the top-level parameter defaults and the canonical word/pointer types.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 32;
  localparam int PTR_W              = $clog2(DEFAULT_FIFO_DEPTH);

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
  // Address bits plus one wrap bit, so full and empty can be told apart.
  typedef logic [PTR_W:0]                ptr_t;

  function automatic bit depth_is_valid(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_memory.sv
// Simple dual-port RAM for the FIFO: synchronous write port, asynchronous read port.
module fifo_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; stale words are never visible because the pointers are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : fifo_memory

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with elaboration-time choice of standard (registered) or FWFT read.
// Status flags come only from the pointer registers.
module sync_fifo_buffer
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int FWFT       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] head_word;
  logic [DATA_WIDTH-1:0] held_word;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop while full frees its slot on the same edge, so the write may go ahead.
  assign rd_en = read_i && !empty_o;
  assign wr_en = write_i && (!full_o || read_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  fifo_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (AW)
  ) u_memory (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data_i),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head_word)
  );

  // Word captured by the most recent accepted read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_word <= '0;
    end else if (rd_en) begin
      held_word <= head_word;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // While empty the last popped word is shown rather than uninitialised memory.
    assign rd_data_o = empty_o ? held_word : head_word;
  end else begin : g_standard
    assign rd_data_o = held_word;
  end

endmodule : sync_fifo_buffer

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench: FWFT and standard instances share stimulus, checked against a queue model.
module tb_sync_fifo_buffer;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 32;

  logic  clk_i = 1'b0;
  logic  rst_i = 1'b1;
  logic  write_i = 1'b0;
  logic  read_i = 1'b0;
  word_t wr_data_i = '0;
  word_t rd_data_fwft, rd_data_std;
  logic  full_fwft, empty_fwft, full_std, empty_std;

  int errors = 0;
  int checks = 0;

  // Reference model: contents in order, plus the word returned by the last accepted read.
  word_t q[$];
  word_t exp_held = '0;

  always #5 clk_i = ~clk_i;

  sync_fifo_buffer #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .wr_data_i(wr_data_i),
    .read_i(read_i), .rd_data_o(rd_data_fwft), .full_o(full_fwft), .empty_o(empty_fwft));

  sync_fifo_buffer #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .wr_data_i(wr_data_i),
    .read_i(read_i), .rd_data_o(rd_data_std), .full_o(full_std), .empty_o(empty_std));

  function automatic word_t exp_fwft();
    return (q.size() != 0) ? q[0] : exp_held;
  endfunction

  // One clock of stimulus; the model applies the accept rules at the edge.
  task automatic cycle(input logic w, input logic r, input word_t d);
    bit acc_r, acc_w;
    write_i = w; read_i = r; wr_data_i = d;
    @(posedge clk_i);
    acc_r = r && (q.size() != 0);
    acc_w = w && ((q.size() < DEPTH) || acc_r);
    if (acc_r) exp_held = q.pop_front();
    if (acc_w) q.push_back(d);
    #1;
    write_i = 1'b0; read_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (empty_fwft !== 1'b1 || empty_std !== 1'b1 || full_fwft !== 1'b0 || full_std !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: empty=%b/%b full=%b/%b, required empty=1 full=0",
               empty_fwft, empty_std, full_fwft, full_std);
    end
    checks++;
    if (rd_data_fwft !== 32'h0 || rd_data_std !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: fwft=%h std=%h, required 0", rd_data_fwft, rd_data_std);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    q.delete();
    exp_held = '0;
  endtask

  task automatic test_empty_read();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
      checks++;
      if (empty_fwft !== 1'b1 || empty_std !== 1'b1 || rd_data_fwft !== 32'h0 || rd_data_std !== 32'h0) begin
        errors++;
        $display("FAIL empty_read[%0d]: empty=%b/%b data=%h/%h, required empty=1 data=0",
                 i, empty_fwft, empty_std, rd_data_fwft, rd_data_std);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, word_t'(i));
      checks++;
      if (full_fwft !== (i == DEPTH-1) || full_std !== (i == DEPTH-1) ||
          empty_fwft !== 1'b0 || empty_std !== 1'b0) begin
        errors++;
        $display("FAIL fill_status[%0d]: full=%b/%b empty=%b/%b, required full=%b empty=0",
                 i, full_fwft, full_std, empty_fwft, empty_std, i == DEPTH-1);
      end
    end
    cycle(1'b1, 1'b0, 32'h0000_DEAD);
    checks++;
    if (full_fwft !== 1'b1 || full_std !== 1'b1 || rd_data_fwft !== 32'h0) begin
      errors++;
      $display("FAIL fill_overflow: full=%b/%b fwft=%h, required full=1 fwft=0",
               full_fwft, full_std, rd_data_fwft);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      checks++;
      if (rd_data_std !== word_t'(i) ||
          rd_data_fwft !== word_t'((i < DEPTH-1) ? i + 1 : DEPTH-1)) begin
        errors++;
        $display("FAIL drain_data[%0d]: std=%h fwft=%h, required std=%h fwft=%h", i,
                 rd_data_std, rd_data_fwft, i, (i < DEPTH-1) ? i + 1 : DEPTH-1);
      end
      checks++;
      if (empty_fwft !== (i == DEPTH-1) || empty_std !== (i == DEPTH-1) || full_fwft !== 1'b0) begin
        errors++;
        $display("FAIL drain_status[%0d]: empty=%b/%b full=%b, required empty=%b full=0",
                 i, empty_fwft, empty_std, full_fwft, i == DEPTH-1);
      end
    end
  endtask

  // Drain everything, comparing every popped word against the model.
  task automatic drain_checked(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle(1'b0, 1'b1, $urandom);
      checks++;
      if (rd_data_std !== exp_held || rd_data_fwft !== exp_fwft() ||
          empty_fwft !== (q.size() == 0) || empty_std !== (q.size() == 0)) begin
        errors++;
        $display("FAIL %s_drain[%0d]: std=%h fwft=%h empty=%b/%b, required std=%h fwft=%h empty=%b",
                 tag, i, rd_data_std, rd_data_fwft, empty_fwft, empty_std,
                 exp_held, exp_fwft(), q.size() == 0);
      end
    end
  endtask

  task automatic test_full_read_write();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, $urandom);
      checks++;
      if (full_fwft !== 1'b1 || full_std !== 1'b1 || q.size() != DEPTH ||
          rd_data_std !== exp_held || rd_data_fwft !== exp_fwft()) begin
        errors++;
        $display("FAIL full_rw[%0d]: full=%b/%b std=%h fwft=%h, required full=1 std=%h fwft=%h",
                 i, full_fwft, full_std, rd_data_std, rd_data_fwft, exp_held, exp_fwft());
      end
    end
    drain_checked("full_rw");
  endtask

  task automatic test_partial_read_write();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, $urandom);
      checks++;
      if (full_fwft !== 1'b0 || empty_fwft !== 1'b0 || empty_std !== 1'b0 || q.size() != 5 ||
          rd_data_std !== exp_held || rd_data_fwft !== exp_fwft()) begin
        errors++;
        $display("FAIL partial_rw[%0d]: full=%b empty=%b/%b std=%h fwft=%h, required full=0 empty=0 std=%h fwft=%h",
                 i, full_fwft, empty_fwft, empty_std, rd_data_std, rd_data_fwft, exp_held, exp_fwft());
      end
    end
    drain_checked("partial_rw");
  endtask

  task automatic test_empty_read_write();
    word_t d;
    d = $urandom;
    cycle(1'b1, 1'b1, d);
    checks++;
    if (empty_fwft !== 1'b0 || rd_data_fwft !== d || rd_data_std !== exp_held) begin
      errors++;
      $display("FAIL empty_rw: empty=%b fwft=%h std=%h, required empty=0 fwft=%h std=%h",
               empty_fwft, rd_data_fwft, rd_data_std, d, exp_held);
    end
    drain_checked("empty_rw");
  endtask

  task automatic test_wrap();
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom);
      checks++;
      if (full_fwft !== 1'b1 || full_std !== 1'b1) begin
        errors++;
        $display("FAIL wrap_full[%0d]: full=%b/%b, required 1", lap, full_fwft, full_std);
      end
      drain_checked("wrap");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), $urandom);
      checks++;
      if (full_fwft !== (q.size() == DEPTH) || full_std !== (q.size() == DEPTH) ||
          empty_fwft !== (q.size() == 0) || empty_std !== (q.size() == 0) ||
          rd_data_std !== exp_held || (q.size() != 0 && rd_data_fwft !== exp_fwft())) begin
        errors++;
        $display("FAIL random[%0d]: full=%b empty=%b std=%h fwft=%h, required full=%b empty=%b std=%h fwft=%h",
                 i, full_fwft, empty_fwft, rd_data_std, rd_data_fwft,
                 q.size() == DEPTH, q.size() == 0, exp_held, exp_fwft());
      end
    end
  endtask

  task automatic test_reset_midstream();
    drain_checked("pre_reset");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'hA000_0000 + i);
    cycle(1'b0, 1'b1, 32'h0);
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (empty_fwft !== 1'b1 || empty_std !== 1'b1 || full_fwft !== 1'b0 ||
        rd_data_std !== 32'h0 || rd_data_fwft !== 32'h0) begin
      errors++;
      $display("FAIL midstream_reset: empty=%b/%b full=%b std=%h fwft=%h, required empty=1 full=0 data=0",
               empty_fwft, empty_std, full_fwft, rd_data_std, rd_data_fwft);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    q.delete();
    exp_held = '0;
    cycle(1'b1, 1'b0, 32'h0000_1234);
    checks++;
    if (empty_fwft !== 1'b0 || rd_data_fwft !== 32'h0000_1234) begin
      errors++;
      $display("FAIL post_reset_fwft: empty=%b fwft=%h, required empty=0 fwft=00001234",
               empty_fwft, rd_data_fwft);
    end
    cycle(1'b0, 1'b1, 32'h0);
    checks++;
    if (rd_data_std !== 32'h0000_1234 || empty_std !== 1'b1 || empty_fwft !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_std: std=%h empty=%b/%b, required std=00001234 empty=1",
               rd_data_std, empty_std, empty_fwft);
    end
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_fill();
    test_drain();
    test_full_read_write();
    test_partial_read_write();
    test_empty_read_write();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo_buffer
